// File: rtl/mem_axil_bridge.sv
// Native mem_valid/mem_ready to single-outstanding AXI4-Lite master bridge.
// Optional watchdog enabled by defining MEM_AXIL_BRIDGE_TIMEOUT_EN.
module mem_axil_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] RD_ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_instr,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic aw_done;
  logic w_done;
  logic ar_hs;
  logic r_hs;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic accept;
  logic is_wr;
  logic busy;
  logic fin;
  logic tmo;

  // Every valid/ready is a pure decode of registered state.
  assign mem_axi_arvalid = (state == RD_ADDR);
  assign mem_axi_rready  = (state == RD_DATA);
  assign mem_axi_awvalid = (state == WR_REQ) && !aw_done;
  assign mem_axi_wvalid  = (state == WR_REQ) && !w_done;
  assign mem_axi_bready  = (state == WR_RESP);
  assign mem_ready       = (state == DONE);
  assign mem_axi_awprot  = 3'b000;

  assign ar_hs  = mem_axi_arvalid && mem_axi_arready;
  assign r_hs   = mem_axi_rready && mem_axi_rvalid;
  assign aw_hs  = mem_axi_awvalid && mem_axi_awready;
  assign w_hs   = mem_axi_wvalid && mem_axi_wready;
  assign b_hs   = mem_axi_bready && mem_axi_bvalid;
  assign accept = (state == IDLE) && mem_valid;
  assign is_wr  = |mem_wstrb;
  assign fin    = r_hs || b_hs;

  assign busy = (state == RD_ADDR) || (state == RD_DATA) ||
                (state == WR_REQ)  || (state == WR_RESP);

`ifdef MEM_AXIL_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  // A transaction completing on the limit cycle wins over the watchdog.
  assign tmo = busy && !fin &&
               (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (busy) tmo_cnt <= tmo_cnt + TW'(1);
      else      tmo_cnt <= '0;
      if (tmo)  err_q   <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg  = (TIMEOUT_CYCLES == 0);
  assign tmo         = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (mem_valid) state_nx = is_wr ? WR_REQ : RD_ADDR;
      RD_ADDR: if (ar_hs) state_nx = RD_DATA;
      RD_DATA: if (r_hs) state_nx = DONE;
      WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs))
                 state_nx = WR_RESP;
      WR_RESP: if (b_hs) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (tmo) state_nx = DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      mem_axi_araddr <= '0;
      mem_axi_arprot <= '0;
      mem_axi_awaddr <= '0;
      mem_axi_wdata  <= '0;
      mem_axi_wstrb  <= '0;
      mem_rdata      <= '0;
      rd_count       <= '0;
      wr_count       <= '0;
    end else begin
      if (accept) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (is_wr) begin
          mem_axi_awaddr <= mem_addr;
          mem_axi_wdata  <= mem_wdata;
          mem_axi_wstrb  <= mem_wstrb;
        end else begin
          mem_axi_araddr <= mem_addr;
          mem_axi_arprot <= {mem_instr, 2'b00};
        end
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (r_hs) begin
        mem_rdata <= mem_axi_rdata;
        rd_count  <= rd_count + 32'd1;
      end
      if (b_hs) wr_count <= wr_count + 32'd1;
      if (tmo && ((state == RD_ADDR) || (state == RD_DATA)))
        mem_rdata <= RD_ERR_DATA;
    end
  end

endmodule

// File: tb/tb_mem_axil_bridge.sv
// Directed bench for mem_axil_bridge with a delay-configurable AXI4-Lite slave.
// Covers reset, reads, strobed writes, channel ordering, reset abort, back-to-back.
module tb_mem_axil_bridge;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [31:0] rd_count, wr_count;
  logic        err_timeout;

  mem_axil_bridge #(.TIMEOUT_CYCLES(TO), .RD_ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready),
    .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
    .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready),
    .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready),
    .mem_axi_rdata(rdata),
    .rd_count(rd_count), .wr_count(wr_count), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return (i == 64) ? 32'h1234_5678 : {b, 8'hC3, ~b, 8'h5A};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // Slave: ready after N waiting cycles, one-cycle commit before B.
  logic [31:0] mem [0:255];
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic r_pend, b_pend, aw_got, w_got;
  logic [31:0] r_data, aw_lat, w_lat;
  logic [3:0] s_lat;

  assign arready = arvalid && (ar_cnt >= ar_dly);
  assign rvalid  = r_pend && (r_cnt >= r_dly);
  assign rdata   = r_data;
  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);
  assign bvalid  = b_pend && (b_cnt >= b_dly);

  always @(posedge clk) begin
    if (rst) begin
      ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      r_data <= '0; aw_lat <= '0; w_lat <= '0; s_lat <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else begin
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (arvalid && arready) begin
        r_pend <= 1'b1;
        r_cnt  <= 0;
        r_data <= mem[araddr[9:2]];
      end else if (r_pend) begin
        if (rvalid && rready) r_pend <= 1'b0;
        else r_cnt <= r_cnt + 1;
      end
      if (awvalid && awready) begin
        aw_got <= 1'b1;
        aw_lat <= awaddr;
      end
      if (wvalid && wready) begin
        w_got <= 1'b1;
        w_lat <= wdata;
        s_lat <= wstrb;
      end
      if (aw_got && w_got) begin
        mem[aw_lat[9:2]] <= merge(mem[aw_lat[9:2]], w_lat, s_lat);
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        b_pend <= 1'b1;
        b_cnt  <= 0;
      end else if (b_pend) begin
        if (bvalid && bready) b_pend <= 1'b0;
        else b_cnt <= b_cnt + 1;
      end
    end
  end

  // Protocol monitor: handshake counts, last payloads, valid/payload stability.
  int ar_n = 0, aw_n = 0, w_n = 0, b_n = 0, viol = 0;
  logic [31:0] last_araddr, last_awaddr, last_wdata;
  logic [2:0]  last_arprot, last_awprot;
  logic [3:0]  last_wstrb;
  logic        p_ar, p_aw, p_w;
  logic [31:0] p_ara, p_awa, p_wd;

  always @(posedge clk) begin
    if (rst) begin
      p_ar <= 1'b0; p_aw <= 1'b0; p_w <= 1'b0;
    end else begin
      if (p_ar && (!arvalid || araddr != p_ara)) viol <= viol + 1;
      if (p_aw && (!awvalid || awaddr != p_awa)) viol <= viol + 1;
      if (p_w && (!wvalid || wdata != p_wd)) viol <= viol + 1;
      p_ar <= arvalid && !arready; p_ara <= araddr;
      p_aw <= awvalid && !awready; p_awa <= awaddr;
      p_w  <= wvalid && !wready;   p_wd  <= wdata;
      if (arvalid && arready) begin
        ar_n <= ar_n + 1;
        last_araddr <= araddr;
        last_arprot <= arprot;
      end
      if (awvalid && awready) begin
        aw_n <= aw_n + 1;
        last_awaddr <= awaddr;
        last_awprot <= awprot;
      end
      if (wvalid && wready) begin
        w_n <= w_n + 1;
        last_wdata <= wdata;
        last_wstrb <= wstrb;
      end
      if (bvalid && bready) begin
        b_n <= b_n + 1;
        if (aw_n != w_n || aw_n != b_n + 1) viol <= viol + 1;
      end
    end
  end

  task automatic req(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic ins, input bit keep,
                     output logic [31:0] rd, output int lat);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    mem_instr = ins;
    lat = 0;
    while (lat < 400) begin
      @(negedge clk);
      lat++;
      if (mem_ready) break;
    end
    check("req_done", 32'(mem_ready), 32'd1);
    rd = mem_rdata;
    if (!keep || !mem_ready) mem_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [31:0] sb [0:255];

  initial begin
    int lat, n, ar0, aw0, nrd, nwr, idx;
    logic [31:0] rd, a, d;
    logic [3:0] s;
    for (int i = 0; i < 256; i++) sb[i] = init_word(i);

    repeat (3) @(negedge clk);
    check("rst_bus", 32'({arvalid, awvalid, wvalid, bready, rready,
                          mem_ready}), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_rdcnt", rd_count, 32'd0);
    check("rst_wrcnt", wr_count, 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    rst = 1'b0;

    req(32'h100, 32'h0, 4'b0000, 1'b1, 1'b0, rd, lat);
    check("rd_lat", 32'(lat), 32'd3);
    check("rd_data", rd, 32'h1234_5678);
    check("rd_araddr", last_araddr, 32'h100);
    check("rd_arprot", 32'(last_arprot), 32'h4);
    check("rd_count", rd_count, 32'd1);
    @(negedge clk);
    check("rd_pulse", 32'(mem_ready), 32'd0);

    req(32'h204, 32'hAABB_CCDD, 4'b0010, 1'b0, 1'b0, rd, lat);
    check("wr_awaddr", last_awaddr, 32'h204);
    check("wr_awprot", 32'(last_awprot), 32'd0);
    check("wr_wdata", last_wdata, 32'hAABB_CCDD);
    check("wr_wstrb", 32'(last_wstrb), 32'h2);
    check("wr_count", wr_count, 32'd1);
    req(32'h204, 32'h0, 4'b0000, 1'b0, 1'b0, rd, lat);
    check("wr_rb", rd, 32'h81C3_CC5A);

    aw_dly = 3; w_dly = 0; b_dly = 4;
    req(32'h10, 32'h0102_0304, 4'b1111, 1'b0, 1'b0, rd, lat);
    aw_dly = 0; w_dly = 3; b_dly = 2;
    req(32'h14, 32'hCAFE_F00D, 4'b1100, 1'b0, 1'b0, rd, lat);
    b_dly = 0; w_dly = 0;
    check("ord_wrcnt", wr_count, 32'd3);
    req(32'h10, 32'h0, 4'b0000, 1'b0, 1'b0, rd, lat);
    check("ord_rb0", rd, 32'h0102_0304);
    req(32'h14, 32'h0, 4'b0000, 1'b0, 1'b0, rd, lat);
    check("ord_rb1", rd, 32'hCAFE_FA5A);

    ar0 = ar_n; aw0 = aw_n;
    req(32'h100, 32'h0, 4'b0000, 1'b0, 1'b1, rd, lat);
    check("b2b_rd0", rd, 32'h1234_5678);
    req(32'h08, 32'h55AA_55AA, 4'b1111, 1'b0, 1'b1, rd, lat);
    req(32'h08, 32'h0, 4'b0000, 1'b0, 1'b0, rd, lat);
    check("b2b_rd1", rd, 32'h55AA_55AA);
    check("b2b_ar", 32'(ar_n - ar0), 32'd2);
    check("b2b_aw", 32'(aw_n - aw0), 32'd1);

    r_dly = 20;
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h40; mem_wstrb = 4'b0000;
    n = 0;
    while (!rready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reach", 32'(rready), 32'd1);
    rst = 1'b1;
    mem_valid = 1'b0;
    @(negedge clk);
    check("midrst_bus", 32'({arvalid, awvalid, wvalid, bready, rready,
                             mem_ready}), 32'd0);
    rst = 1'b0;
    r_dly = 0;
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (mem_ready) n++;
    end
    check("midrst_noready", 32'(n), 32'd0);
    check("midrst_rdcnt", rd_count, 32'd0);
    for (int i = 0; i < 256; i++) sb[i] = init_word(i);
    req(32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, rd, lat);
    check("midrst_rd0", rd, 32'h00C3_FF5A);
    nrd = 1; nwr = 0;

    for (int k = 0; k < 60; k++) begin
      ar_dly = $urandom_range(0, 3);
      r_dly  = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3);
      w_dly  = $urandom_range(0, 3);
      b_dly  = $urandom_range(0, 3);
      idx = $urandom_range(0, 63);
      a = 32'(idx) << 2;
      s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
      d = $urandom;
      req(a, d, s, 1'b0, 1'b0, rd, lat);
      if (s == 4'b0) begin
        check("mix_rd", rd, sb[idx]);
        nrd++;
      end else begin
        sb[idx] = merge(sb[idx], d, s);
        nwr++;
      end
    end
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
    check("mix_rdcnt", rd_count, 32'(nrd));
    check("mix_wrcnt", wr_count, 32'(nwr));

`ifdef MEM_AXIL_BRIDGE_TIMEOUT_EN
    ar_dly = 100000;
    req(32'h0C, 32'h0, 4'b0000, 1'b0, 1'b0, rd, lat);
    check("to_lat", 32'(lat), 32'(TO + 1));
    check("to_data", rd, 32'hDEAD_BEEF);
    check("to_err", 32'(err_timeout), 32'd1);
    check("to_rdcnt", rd_count, 32'(nrd));
    ar_dly = 0;
`else
    check("no_err", 32'(err_timeout), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("proto_viol", 32'(viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
